// File: rtl/ldl_sfifo_p2ram_ctrl_pkg.sv
// Shared constants, types and helpers for the RAM-backed synchronous FIFO controller.
package ldl_sfifo_pkg;

  localparam int unsigned OBUF_DEPTH = 3;

  typedef logic [1:0] obuf_cnt_t;

  // Increment that wraps at an arbitrary depth (depth need not be a power of two).
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ldl_sfifo_p2ram_ctrl_if.sv
// Producer/consumer stream bundle for the FIFO controller.
interface ldl_sfifo_p2ram_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ldl_sfifo_p2ram_ctrl_obuf.sv
// Three-entry register FIFO that hides the RAM read latency from the consumer.
module ldl_sfifo_obuf
  import ldl_sfifo_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output obuf_cnt_t     cnt_o
);

  localparam obuf_cnt_t FULL = obuf_cnt_t'(OBUF_DEPTH);

  logic [DW-1:0] mem_q [OBUF_DEPTH];
  logic [1:0]    rd_q, rd_d;
  logic [1:0]    wr_q, wr_d;
  obuf_cnt_t     cnt_q, cnt_d;
  logic          pop_en;
  logic          push_en;

  // A push into a full buffer is legal when a pop frees the head in the same cycle.
  always_comb begin
    pop_en  = pop_i && (cnt_q != '0);
    push_en = push_i && ((cnt_q != FULL) || pop_en);
    rd_d    = pop_en  ? 2'(ptr_inc(32'(rd_q), OBUF_DEPTH)) : rd_q;
    wr_d    = push_en ? 2'(ptr_inc(32'(wr_q), OBUF_DEPTH)) : wr_q;
    cnt_d   = cnt_q;
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/ldl_sfifo_p2ram_ctrl.sv
// FIFO controller for an external simple dual-port RAM with a registered read port;
// presents first-word-fall-through valid/ready streams on both sides.
module ldl_sfifo_p2ram_ctrl
  import ldl_sfifo_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 10,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned LW    = $clog2(DEPTH + 4)
) (
  input  logic                    clk,
  input  logic                    rst,
  ldl_sfifo_p2ram_ctrl_if.slave   s,
  output logic                    ram_we,
  output logic [AW-1:0]           ram_wa,
  output logic [DW-1:0]           ram_din,
  output logic                    ram_re,
  output logic [AW-1:0]           ram_ra,
  input  logic [DW-1:0]           ram_dout,
  input  logic                    ram_rv,
  output logic [LW-1:0]           level,
  output logic                    err
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] ram_cnt_q, ram_cnt_d;
  logic          inflight_q, inflight_d;
  logic          err_q, err_d;
  logic [LW-1:0] level_q, level_d;

  logic          in_ready;
  logic          accept;
  logic          issue;
  logic          capture;
  logic          pop;
  logic          obuf_valid;
  logic [DW-1:0] obuf_data;
  obuf_cnt_t     obuf_cnt;
  logic [LW-1:0] obuf_cnt_nxt;

  assign in_ready = (ram_cnt_q < DEPTH_L);
  assign accept   = s.in_valid && in_ready;
  // Never request more reads than the output buffer can absorb, counting the one in flight.
  assign issue    = (ram_cnt_q != '0) &&
                    (({1'b0, obuf_cnt} + {2'b00, inflight_q}) < 3'd3);
  assign capture  = inflight_q && ram_rv;
  assign pop      = obuf_valid && s.out_ready;

  always_comb begin
    wptr_d     = accept ? AW'(ptr_inc(32'(wptr_q), DEPTH)) : wptr_q;
    rptr_d     = issue  ? AW'(ptr_inc(32'(rptr_q), DEPTH)) : rptr_q;
    inflight_d = issue;
    err_d      = err_q || (inflight_q && !ram_rv);
    ram_cnt_d  = ram_cnt_q;
    case ({accept, issue})
      2'b10:   ram_cnt_d = ram_cnt_q + LW'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - LW'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
    obuf_cnt_nxt = LW'(obuf_cnt) + LW'(capture) - LW'(pop);
    level_d      = ram_cnt_d + LW'(inflight_d) + obuf_cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      level_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      level_q    <= level_d;
    end
  end

  ldl_sfifo_obuf #(
    .DW (DW)
  ) u_obuf (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (capture),
    .data_i  (ram_dout),
    .pop_i   (pop),
    .valid_o (obuf_valid),
    .data_o  (obuf_data),
    .cnt_o   (obuf_cnt)
  );

  assign s.in_ready  = in_ready;
  assign s.out_valid = obuf_valid;
  assign s.out_data  = obuf_data;

  assign ram_we  = accept;
  assign ram_wa  = wptr_q;
  assign ram_din = s.in_data;
  assign ram_re  = issue;
  assign ram_ra  = rptr_q;

  assign level = level_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ldl_sfifo_p2ram_ctrl.sv
// Scoreboard bench for ldl_sfifo_p2ram_ctrl with a behavioural registered-read RAM.
module tb_ldl_sfifo_p2ram_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = $clog2(DEPTH + 4);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldl_sfifo_p2ram_ctrl_if #(.DW(DW)) bus ();

  logic          ram_we, ram_re;
  logic [AW-1:0] ram_wa, ram_ra;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          rv_q = 1'b0;
  logic          rv_kill = 1'b0;
  logic          ram_rv;
  logic [LW-1:0] level;
  logic          err;
  logic [DW-1:0] mem [DEPTH];

  // RAM model is deliberately not reset so stale read-valids can reach the DUT.
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_din;
    ram_dout <= mem[ram_ra];
    rv_q     <= ram_re;
  end
  assign ram_rv = rv_q & ~rv_kill;

  ldl_sfifo_p2ram_ctrl #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (bus),
    .ram_we   (ram_we),
    .ram_wa   (ram_wa),
    .ram_din  (ram_din),
    .ram_re   (ram_re),
    .ram_ra   (ram_ra),
    .ram_dout (ram_dout),
    .ram_rv   (ram_rv),
    .level    (level),
    .err      (err)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [DW-1:0] exp_q [$];
  bit chk_level = 1'b1;
  int cyc = 0, pops = 0, first_pop = -1, last_pop = -1, wrap_w = 0, wrap_r = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Events seen here take effect at the following rising edge.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (chk_level) check("level", 32'(level), exp_q.size());
      if (ram_we && ram_re) check("addr_clash", 32'(ram_wa == ram_ra), 0);
      if (ram_we && ram_wa == AW'(DEPTH - 1)) wrap_w++;
      if (ram_re && ram_ra == AW'(DEPTH - 1)) wrap_r++;
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e));
        end
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        tick();
        return;
      end
      tick();
    end
    check("push_timeout", 32'(bus.in_ready), 1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 64; t++) begin
      if (level == '0 && !bus.out_valid) break;
      tick();
    end
    check("drain_level", 32'(level), 0);
    check("drain_valid", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_re", 32'(ram_re), 0);
    check("rst_err", 32'(err), 0);

    // Single entry latency
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    check("lat_e0_valid", 32'(bus.out_valid), 0);
    tick();
    check("lat_e1_valid", 32'(bus.out_valid), 0);
    tick();
    check("lat_e2_valid", 32'(bus.out_valid), 1);
    check("single_data", 32'(bus.out_data), 32'h0000_00A5);
    check("single_level", 32'(level), 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("single_pop_valid", 32'(bus.out_valid), 0);
    check("single_pop_level", 32'(level), 0);

    // Fill to capacity
    for (int i = 0; i < 13; i++) push_word(8'(i));
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("fill_in_ready", 32'(bus.in_ready), 0);
    check("fill_level", 32'(level), 13);
    check("fill_err", 32'(err), 0);
    drain();

    // Streaming across pointer wrap
    pops = 0; first_pop = -1; last_pop = -1; wrap_w = 0; wrap_r = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 25; i++) push_word(8'(8'h10 + i));
    bus.in_valid = 1'b0;
    for (int t = 0; t < 10 && level != '0; t++) tick();
    bus.out_ready = 1'b0;
    check("stream_pops", pops, 25);
    check("stream_span", last_pop - first_pop, 24);
    check("stream_wrap_w", wrap_w, 2);
    check("stream_wrap_r", wrap_r, 2);

    // Full, then a single pop frees space
    for (int i = 0; i < 13; i++) push_word(8'(8'h30 + i));
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("full_level", 32'(level), 13);
    check("full_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h3D;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    w = 0;
    while (!bus.in_ready && w < 4) begin
      tick();
      w++;
    end
    check("full_ready_lat", w, 1);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("refull_level", 32'(level), 13);
    check("refull_in_ready", 32'(bus.in_ready), 0);
    drain();

    // Reset while a read is in flight, with a stale read-valid afterwards
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    tick();
    bus.in_data  = 8'h78;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    check("pre_rst_rv", 32'(ram_rv), 1);
    tick();
    rst = 1'b0;
    check("mrst_level", 32'(level), 0);
    check("mrst_out_valid", 32'(bus.out_valid), 0);
    check("mrst_in_ready", 32'(bus.in_ready), 1);
    check("mrst_stale_rv", 32'(ram_rv), 1);
    check("mrst_err", 32'(err), 0);
    tick();
    check("stale_err", 32'(err), 0);
    check("stale_out_valid", 32'(bus.out_valid), 0);
    check("stale_level", 32'(level), 0);
    push_word(8'h55);
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("post_rst_valid", 32'(bus.out_valid), 1);
    check("post_rst_data", 32'(bus.out_data), 32'h0000_0055);
    drain();

    // Missing read-valid sets the sticky error
    chk_level = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h66;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rv_kill = 1'b1;
    check("err_before", 32'(err), 0);
    tick();
    rv_kill = 1'b0;
    check("err_set", 32'(err), 1);
    repeat (5) tick();
    check("err_sticky", 32'(err), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_level = 1'b1;
    check("err_cleared", 32'(err), 0);
    check("err_rst_level", 32'(level), 0);

    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
